// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and the EX/MEM / MEM/WB record type for the MEM and WB pipeline stages.
package mem_wb_pipe_pkg;

  localparam int DEF_REG_W  = 7;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  // Everything a stage carries except the destination register, whose width is a module parameter.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] alu;
    logic                  load;
    logic [1:0]            size;
    logic                  sgn;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '{alu: '0, load: 1'b0, size: LOAD_BYTE, sgn: 1'b0};

endpackage

// File: rtl/mem_wb_pipe_load_align.sv
// Combinational load-data aligner: picks the addressed byte/half of a little-endian word and extends it.
module mem_wb_pipe_load_align
  import mem_wb_pipe_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = raw[{off, 3'b000} +: 8];
    half_v = off[1] ? raw[31:16] : raw[15:0];
    data   = raw;
    case (size)
      LOAD_BYTE: data = {{24{sgn & byte_v[7]}}, byte_v};
      LOAD_HALF: data = {{16{sgn & half_v[15]}}, half_v};
      default:   data = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with load-use bubble insertion and WB load alignment.
// Optional perf counters are enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int REG_W  = DEF_REG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ExValid,
  input  logic              ExRegWrite,
  input  logic [REG_W-1:0]  ExRegNumber,
  input  logic [DATA_W-1:0] ExAluResult,
  input  logic              ExLoad,
  input  logic [1:0]        ExLoadSize,
  input  logic              ExLoadSigned,
  input  logic              LoadStore,
  input  logic              Flush,
  input  logic              Freeze,
  input  logic [DATA_W-1:0] MemReadData,
  output logic [REG_W-1:0]  MEMRegisterNumber,
  output logic [DATA_W-1:0] MEMAluResultData,
  output logic              MEMLoad,
  output logic [REG_W-1:0]  WBRegisterNumber,
  output logic [DATA_W-1:0] WBAluResultData,
  output logic [DATA_W-1:0] WBReadData,
  output logic              WBLoad,
  output logic              WBRegWrite,
  output logic [31:0]       BubbleCount,
  output logic [31:0]       FreezeCount
);

  stage_rec_t       ex_rec, mem_rec, wb_rec;
  logic [REG_W-1:0] ex_dst, mem_dst, wb_dst;
  logic [31:0]      wb_aligned;

  // There is no valid/ready handshake here: Freeze is the only backpressure and
  // holds both registers; an invalid or non-writing instruction is encoded as dst 0.
  always_comb begin
    ex_rec      = STAGE_BUBBLE;
    ex_rec.alu  = ExAluResult;
    ex_rec.load = ExValid & ExLoad;
    ex_rec.size = ExLoadSize;
    ex_rec.sgn  = ExLoadSigned;
    ex_dst      = (ExValid & ExRegWrite) ? ExRegNumber : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rec <= STAGE_BUBBLE;
      mem_dst <= '0;
      wb_rec  <= STAGE_BUBBLE;
      wb_dst  <= '0;
    end else if (!Freeze) begin
      if (Flush | LoadStore) begin
        mem_rec <= STAGE_BUBBLE;
        mem_dst <= '0;
      end else begin
        mem_rec <= ex_rec;
        mem_dst <= ex_dst;
      end
      wb_rec <= mem_rec;
      wb_dst <= mem_dst;
    end
  end

  mem_wb_pipe_load_align u_align (
    .size (wb_rec.size),
    .sgn  (wb_rec.sgn),
    .off  (wb_rec.alu[1:0]),
    .raw  (MemReadData),
    .data (wb_aligned)
  );

  assign MEMRegisterNumber = mem_dst;
  assign MEMAluResultData  = mem_rec.alu;
  assign MEMLoad           = mem_rec.load;
  assign WBRegisterNumber  = wb_dst;
  assign WBAluResultData   = wb_rec.alu;
  assign WBLoad            = wb_rec.load;
  assign WBRegWrite        = |wb_dst;
  assign WBReadData        = wb_rec.load ? wb_aligned : '0;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] bubble_cnt, freeze_cnt;

  // A bubble is only counted when the stage actually advanced.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      freeze_cnt <= '0;
    end else if (Freeze) begin
      freeze_cnt <= freeze_cnt + 32'd1;
    end else if (Flush | LoadStore) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign BubbleCount = bubble_cnt;
  assign FreezeCount = freeze_cnt;
`else
  assign BubbleCount = '0;
  assign FreezeCount = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: drivers queue expected field values per cycle, a negedge monitor checks them.
module tb_mem_wb_pipe;

`ifdef MEM_WB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int F_MREG = 0, F_MALU = 1, F_MLD = 2, F_WREG = 3, F_WALU = 4;
  localparam int F_WRD = 5, F_WLD = 6, F_WRW = 7, F_BUB = 8, F_FRZ = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ExValid = 1'b0, ExRegWrite = 1'b0, ExLoad = 1'b0, ExLoadSigned = 1'b0;
  logic [6:0]  ExRegNumber = '0;
  logic [31:0] ExAluResult = '0;
  logic [1:0]  ExLoadSize = 2'b00;
  logic        LoadStore = 1'b0, Flush = 1'b0, Freeze = 1'b0;
  logic [31:0] MemReadData = '0;
  logic [6:0]  MEMRegisterNumber, WBRegisterNumber;
  logic [31:0] MEMAluResultData, WBAluResultData, WBReadData, BubbleCount, FreezeCount;
  logic        MEMLoad, WBLoad, WBRegWrite;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst), .ExValid(ExValid), .ExRegWrite(ExRegWrite),
    .ExRegNumber(ExRegNumber), .ExAluResult(ExAluResult), .ExLoad(ExLoad),
    .ExLoadSize(ExLoadSize), .ExLoadSigned(ExLoadSigned), .LoadStore(LoadStore),
    .Flush(Flush), .Freeze(Freeze), .MemReadData(MemReadData),
    .MEMRegisterNumber(MEMRegisterNumber), .MEMAluResultData(MEMAluResultData),
    .MEMLoad(MEMLoad), .WBRegisterNumber(WBRegisterNumber), .WBAluResultData(WBAluResultData),
    .WBReadData(WBReadData), .WBLoad(WBLoad), .WBRegWrite(WBRegWrite),
    .BubbleCount(BubbleCount), .FreezeCount(FreezeCount)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_fld_q[$];
  string       exp_name_q[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] get_field(int f);
    case (f)
      F_MREG:  return {25'd0, MEMRegisterNumber};
      F_MALU:  return MEMAluResultData;
      F_MLD:   return {31'd0, MEMLoad};
      F_WREG:  return {25'd0, WBRegisterNumber};
      F_WALU:  return WBAluResultData;
      F_WRD:   return WBReadData;
      F_WLD:   return {31'd0, WBLoad};
      F_WRW:   return {31'd0, WBRegWrite};
      F_BUB:   return BubbleCount;
      default: return FreezeCount;
    endcase
  endfunction

  task automatic expect_at(input int dcyc, input int fld, input logic [31:0] v, input string name);
    exp_cyc_q.push_back(cyc + dcyc);
    exp_fld_q.push_back(fld);
    exp_q.push_back(v);
    exp_name_q.push_back(name);
  endtask

  task automatic expect_all_zero(input int dcyc, input string name);
    for (int f = 0; f <= F_FRZ; f++) expect_at(dcyc, f, 32'd0, $sformatf("%s_f%0d", name, f));
  endtask

  // monitor
  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      int          c, f;
      logic [31:0] e, a;
      string       n;
      c = exp_cyc_q.pop_front();
      f = exp_fld_q.pop_front();
      e = exp_q.pop_front();
      n = exp_name_q.pop_front();
      a = get_field(f);
      total++;
      if (c != cyc) begin
        bad++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", n, c, cyc);
      end else if (a !== e) begin
        bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", n, a, e, cyc);
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rw, input logic [6:0] rn, input logic [31:0] alu,
                          input logic ld, input logic [1:0] sz, input logic sg);
    ExValid = v; ExRegWrite = rw; ExRegNumber = rn; ExAluResult = alu;
    ExLoad = ld; ExLoadSize = sz; ExLoadSigned = sg;
  endtask

  task automatic drive_idle();
    drive_ex(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 2'b00, 1'b0);
  endtask

  // Issue one load, check its WB data two cycles later, then drain.
  task automatic load_case(input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] raw, input logic [31:0] exp_v, input string name);
    MemReadData = raw;
    drive_ex(1'b1, 1'b1, 7'd7, addr, 1'b1, sz, sg);
    expect_at(1, F_MLD, 32'd1, {name, "_memload"});
    expect_at(2, F_WLD, 32'd1, {name, "_wbload"});
    expect_at(2, F_WRD, exp_v, {name, "_data"});
    tick();
    drive_idle();
    tick();
    tick();
  endtask

  initial begin
    // reset
    tick();
    tick();
    expect_all_zero(0, "reset");
    rst = 1'b0;
    drive_idle();

    // plain ALU op r5
    MemReadData = 32'hDEAD_BEEF;
    drive_ex(1'b1, 1'b1, 7'd5, 32'h1234_5678, 1'b0, 2'b10, 1'b0);
    expect_at(1, F_MREG, 32'd5, "alu_memreg");
    expect_at(1, F_MALU, 32'h1234_5678, "alu_memalu");
    expect_at(2, F_WREG, 32'd5, "alu_wbreg");
    expect_at(2, F_WALU, 32'h1234_5678, "alu_wbalu");
    expect_at(2, F_WLD, 32'd0, "alu_wbload");
    expect_at(2, F_WRD, 32'd0, "alu_wbrd_zero");
    expect_at(2, F_WRW, 32'd1, "alu_wbregwrite");
    tick();
    drive_idle();
    tick();
    tick();

    // load alignment
    load_case(32'h0000_1003, 2'b00, 1'b1, 32'h80FF_0011, 32'hFFFF_FF80, "lb_s");
    load_case(32'h0000_1003, 2'b00, 1'b0, 32'h80FF_0011, 32'h0000_0080, "lb_u");
    load_case(32'h0000_1000, 2'b00, 1'b1, 32'h80FF_0011, 32'h0000_0011, "lb_s_pos");
    load_case(32'h0000_1002, 2'b01, 1'b0, 32'hBEEF_CAFE, 32'h0000_BEEF, "lh_u2");
    load_case(32'h0000_1001, 2'b01, 1'b0, 32'hBEEF_CAFE, 32'h0000_CAFE, "lh_u1");
    load_case(32'h0000_1002, 2'b01, 1'b1, 32'hBEEF_CAFE, 32'hFFFF_BEEF, "lh_s2");
    load_case(32'h0000_1003, 2'b10, 1'b1, 32'hBEEF_CAFE, 32'hBEEF_CAFE, "lw");
    load_case(32'h0000_1001, 2'b11, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF, "lrsv");

    // load-use stall: load r3 in MEM, r4 in EX bubbled
    drive_ex(1'b1, 1'b1, 7'd3, 32'h0000_2000, 1'b1, 2'b10, 1'b0);
    tick();
    drive_ex(1'b1, 1'b1, 7'd4, 32'h0000_0044, 1'b0, 2'b10, 1'b0);
    LoadStore = 1'b1;
    expect_at(1, F_MREG, 32'd0, "ls_memreg");
    expect_at(1, F_MLD, 32'd0, "ls_memload");
    expect_at(1, F_MALU, 32'd0, "ls_memalu");
    expect_at(1, F_WREG, 32'd3, "ls_wbreg");
    expect_at(1, F_WLD, 32'd1, "ls_wbload");
    expect_at(1, F_BUB, PERF ? 32'd1 : 32'd0, "ls_bubcnt");
    tick();
    LoadStore = 1'b0;
    expect_at(1, F_MREG, 32'd4, "ls_replay_memreg");
    tick();

    // flush and load-use together count one bubble
    drive_ex(1'b1, 1'b1, 7'd6, 32'h0000_0066, 1'b0, 2'b10, 1'b0);
    Flush = 1'b1;
    LoadStore = 1'b1;
    expect_at(1, F_MREG, 32'd0, "fl_memreg");
    expect_at(1, F_WREG, 32'd4, "fl_wbreg");
    expect_at(1, F_BUB, PERF ? 32'd2 : 32'd0, "fl_bubcnt");
    tick();
    Flush = 1'b0;
    LoadStore = 1'b0;
    drive_idle();
    tick();

    // freeze with live MEM/WB contents
    drive_ex(1'b1, 1'b1, 7'd10, 32'h0000_000A, 1'b0, 2'b10, 1'b0);
    tick();
    drive_ex(1'b1, 1'b1, 7'd11, 32'h0000_000B, 1'b0, 2'b10, 1'b0);
    tick();
    drive_ex(1'b1, 1'b1, 7'd12, 32'h0000_000C, 1'b0, 2'b10, 1'b0);
    Freeze = 1'b1;
    Flush = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      expect_at(k, F_MREG, 32'd11, $sformatf("frz%0d_memreg", k));
      expect_at(k, F_MALU, 32'h0000_000B, $sformatf("frz%0d_memalu", k));
      expect_at(k, F_WREG, 32'd10, $sformatf("frz%0d_wbreg", k));
      expect_at(k, F_WALU, 32'h0000_000A, $sformatf("frz%0d_wbalu", k));
      expect_at(k, F_WRW, 32'd1, $sformatf("frz%0d_wbrw", k));
      expect_at(k, F_FRZ, PERF ? k : 0, $sformatf("frz%0d_cnt", k));
      expect_at(k, F_BUB, PERF ? 32'd2 : 32'd0, $sformatf("frz%0d_bubcnt", k));
    end
    tick();
    Flush = 1'b0;
    tick();
    tick();
    Freeze = 1'b0;
    expect_at(1, F_MREG, 32'd12, "unfrz_memreg");
    expect_at(1, F_WREG, 32'd11, "unfrz_wbreg");
    expect_at(1, F_FRZ, PERF ? 32'd3 : 32'd0, "unfrz_cnt");
    tick();

    // destination rules
    drive_ex(1'b1, 1'b0, 7'd9, 32'h0000_0099, 1'b0, 2'b10, 1'b0);
    expect_at(1, F_MREG, 32'd0, "norw_memreg");
    expect_at(2, F_WRW, 32'd0, "norw_wbrw");
    tick();
    drive_ex(1'b0, 1'b1, 7'd9, 32'h0000_0099, 1'b1, 2'b10, 1'b0);
    expect_at(1, F_MREG, 32'd0, "inv_memreg");
    expect_at(1, F_MLD, 32'd0, "inv_memload");
    tick();
    MemReadData = 32'h0BAD_F00D;
    drive_ex(1'b1, 1'b1, 7'd0, 32'h0000_3000, 1'b1, 2'b10, 1'b0);
    expect_at(2, F_WLD, 32'd1, "r0ld_wbload");
    expect_at(2, F_WRW, 32'd0, "r0ld_wbrw");
    expect_at(2, F_WRD, 32'h0BAD_F00D, "r0ld_data");
    tick();
    drive_ex(1'b1, 1'b1, 7'd13, 32'h0000_000D, 1'b0, 2'b10, 1'b0);
    tick();
    drive_ex(1'b1, 1'b1, 7'd14, 32'h0000_000E, 1'b1, 2'b10, 1'b0);
    tick();

    // reset during freeze
    Freeze = 1'b1;
    rst = 1'b1;
    expect_all_zero(1, "rstfrz");
    tick();
    rst = 1'b0;
    Freeze = 1'b0;
    drive_idle();
    tick();

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) tick();
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain_timeout: %0d checks left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
